// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: 4-way round-robin FIFO write arbiter with per-requester 16-bit word counters.
// Latency: one idle arbitration cycle per grant, then ACK/WDATA/WINC combinational; stats one cycle behind.
// Backpressure: WFULL stalls the grant indefinitely; `FIFO_WR_ARB_BURST_EN holds a grant for up to BURST words.
module fifo_wr_arb #(
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         REQ,
  input  logic [4*DSIZE-1:0] DIN,
  output logic [3:0]         ACK,
  output logic [DSIZE-1:0]   WDATA,
  output logic               WINC,
  input  logic               WFULL,
  output logic [1:0]         GNT,
  output logic               BUSY,
  input  logic [1:0]         STAT_SEL,
  input  logic               STAT_CLR,
  output logic [15:0]        STAT_CNT
);
  localparam int BW = $clog2(BURST + 1);
`ifdef FIFO_WR_ARB_BURST_EN
  localparam logic [BW-1:0] LIMIT = BW'(BURST);
`else
  localparam logic [BW-1:0] LIMIT = BW'(1);
`endif

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [1:0]    gnt_nxt;
  logic [1:0]    sel;
  logic [BW-1:0] bcnt, bcnt_nxt, bcnt_inc;
  logic          take;
  logic [15:0]   cnt_vec [4];

  assign take     = (state == XFER) & REQ[GNT] & ~WFULL & ~RST;
  assign bcnt_inc = bcnt + BW'(1);
  assign ACK      = take ? (4'b0001 << GNT) : 4'b0000;
  assign WINC     = |ACK;
  assign WDATA    = DIN[GNT*DSIZE +: DSIZE];

  always_comb begin
    state_nxt = state;
    gnt_nxt   = GNT;
    ptr_nxt   = ptr;
    bcnt_nxt  = bcnt;
    sel       = ptr;
    // Scan from the farthest offset down so the nearest requester at/after ptr wins.
    for (int k = 3; k >= 0; k--) begin
      if (REQ[ptr + 2'(k)]) sel = ptr + 2'(k);
    end
    case (state)
      IDLE: begin
        if (|REQ) begin
          gnt_nxt   = sel;
          bcnt_nxt  = '0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (take) bcnt_nxt = bcnt_inc;
        if (!REQ[GNT] || (take && bcnt_inc == LIMIT)) begin
          state_nxt = IDLE;
          ptr_nxt   = GNT + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= 2'd0;
      GNT   <= 2'd0;
      BUSY  <= 1'b0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      GNT   <= gnt_nxt;
      BUSY  <= (state_nxt == XFER);
      bcnt  <= bcnt_nxt;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    logic [15:0] cnt;
    // A clear on the selected requester overrides a same-edge accept.
    always_ff @(posedge CLK) begin
      if (RST || (STAT_CLR && STAT_SEL == 2'(i))) cnt <= 16'd0;
      else if (ACK[i])                             cnt <= cnt + 16'd1;
    end
    assign cnt_vec[i] = cnt;
  end

  always_ff @(posedge CLK) begin
    if (RST) STAT_CNT <= 16'd0;
    else     STAT_CNT <= cnt_vec[STAT_SEL];
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb; expected writes queued at stimulus time, checked by a negedge monitor.
module tb_fifo_wr_arb;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam int LIM = 4;
`else
  localparam int LIM = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ;
  logic [31:0] DIN;
  logic [3:0]  ACK;
  logic [7:0]  WDATA;
  logic        WINC;
  logic        WFULL;
  logic [1:0]  GNT;
  logic        BUSY;
  logic [1:0]  STAT_SEL;
  logic        STAT_CLR;
  logic [15:0] STAT_CNT;

  fifo_wr_arb #(.DSIZE(8), .BURST(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DIN(DIN), .ACK(ACK), .WDATA(WDATA),
    .WINC(WINC), .WFULL(WFULL), .GNT(GNT), .BUSY(BUSY),
    .STAT_SEL(STAT_SEL), .STAT_CLR(STAT_CLR), .STAT_CNT(STAT_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] ack;
    logic [1:0] gnt;
    logic [7:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] exp_cnt [4];
  int          vecs = 0;
  int          errs = 0;
  int          nwr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] idx, input logic [7:0] d);
    exp_t e;
    e.ack  = 4'b0001 << idx;
    e.gnt  = idx;
    e.data = d;
    sb.push_back(e);
    exp_cnt[idx] = exp_cnt[idx] + 16'd1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Returns just after the clock edge that performed write number 'target'.
  task automatic wait_writes(input int target, input string name, output int cyc);
    cyc = 0;
    while (nwr < target && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check(name, nwr, target);
  endtask

  task automatic check_stat(input logic [1:0] i, input string name);
    STAT_SEL = i;
    tick(1);
    check(name, STAT_CNT, exp_cnt[i]);
  endtask

  always @(negedge CLK) begin
    if (WINC) begin
      nwr++;
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_write: got ack %b data %h, expected no write", ACK, WDATA);
      end else begin
        mon_e = sb.pop_front();
        check("wr_ack", ACK, mon_e.ack);
        check("wr_data", WDATA, mon_e.data);
        check("wr_gnt", GNT, mon_e.gnt);
      end
    end else if (ACK != 4'b0000) begin
      vecs++;
      errs++;
      $display("FAIL ack_without_winc: got ack %b, expected 0000", ACK);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int na;
    int base;
    logic [1:0] idx;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 16'd0;
    RST = 1'b1; REQ = 4'b0000; DIN = 32'hD3D2D1D0; WFULL = 1'b0;
    STAT_SEL = 2'd0; STAT_CLR = 1'b0;
    tick(2);
    check("rst_gnt", GNT, 2'd0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_stat", STAT_CNT, 16'd0);
    check("rst_ack", ACK, 4'b0000);
    check("rst_winc", WINC, 1'b0);
    RST = 1'b0;
    tick(1);

    // All four requesting: burst grants rotate 0,1,2,3 with one idle cycle per grant.
    na = (LIM == 1) ? 5 : 16;
    for (int k = 0; k < na; k++) begin
      idx = 2'((k / LIM) % 4);
      push(idx, 8'hD0 + 8'(idx));
    end
    REQ = 4'b1111;
    wait_writes(na, "rr_writes", cyc);
    check("rr_cycles", cyc, (na / LIM) * (LIM + 1));
    REQ = 4'b0000;
    for (int i = 0; i < 4; i++) check_stat(2'(i), "rr_stat");

    // Single requester 2 with a 3-cycle WFULL stall after its first word.
    base = nwr;
    REQ = 4'b0100;
    for (int w = 0; w < 4; w++) begin
      DIN[23:16] = 8'h50 + 8'(w);
      push(2'd2, 8'h50 + 8'(w));
      wait_writes(base + w + 1, "stall_writes", cyc);
      if (w == 0) begin
        WFULL = 1'b1;
        for (int s = 0; s < 3; s++) begin
          check("stall_winc", WINC, 1'b0);
          check("stall_busy", BUSY, (LIM > 1 || s > 0) ? 1'b1 : 1'b0);
          tick(1);
        end
        WFULL = 1'b0;
      end
    end
    check("stall_end_busy", BUSY, 1'b0);
    REQ = 4'b0000;
    tick(1);
    check_stat(2'd2, "stall_stat");

    // Requester drops while FIFO is full: abandon the grant, write nothing.
    REQ = 4'b0001; WFULL = 1'b1;
    tick(2);
    check("drop_busy", BUSY, 1'b1);
    check("drop_gnt", GNT, 2'd0);
    check("drop_winc", WINC, 1'b0);
    REQ = 4'b0000;
    tick(1);
    check("drop_idle", BUSY, 1'b0);
    WFULL = 1'b0;
    tick(1);
    check("drop_stay", BUSY, 1'b0);
    check_stat(2'd0, "drop_stat");

    // Counter 1 wraps from 0xFFFF.
    force dut.g_cnt[1].cnt = 16'hFFFF;
    tick(1);
    release dut.g_cnt[1].cnt;
    exp_cnt[1] = 16'hFFFF;
    check_stat(2'd1, "wrap_pre");
    base = nwr;
    push(2'd1, 8'hD1);
    REQ = 4'b0010;
    wait_writes(base + 1, "wrap_write", cyc);
    REQ = 4'b0000;
    tick(1);
    check("wrap_stat", STAT_CNT, 16'h0000);

    // Clear on the same edge as an accept on the selected requester.
    force dut.g_cnt[1].cnt = 16'h1234;
    tick(1);
    release dut.g_cnt[1].cnt;
    exp_cnt[1] = 16'h1234;
    check_stat(2'd1, "clr_pre");
    push(2'd1, 8'hD1);
    REQ = 4'b0010;
    cyc = 0;
    @(negedge CLK);
    while (!WINC && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    check("clr_winc", WINC, 1'b1);
    STAT_CLR = 1'b1;
    tick(1);
    STAT_CLR = 1'b0; REQ = 4'b0000;
    exp_cnt[1] = 16'd0;
    tick(1);
    check("clr_stat", STAT_CNT, 16'h0000);

    // Plain clear of counter 2 leaves counter 0 untouched.
    STAT_SEL = 2'd2; STAT_CLR = 1'b1;
    tick(1);
    STAT_CLR = 1'b0;
    exp_cnt[2] = 16'd0;
    check_stat(2'd2, "clr2_stat");
    check_stat(2'd0, "clr0_keep");

    // Reset in the middle of a grant to requester 3 after two words.
    base = nwr;
    STAT_SEL = 2'd3;
    push(2'd3, 8'hD3);
    push(2'd3, 8'hD3);
    REQ = 4'b1000;
    wait_writes(base + 2, "rst_pre_writes", cyc);
    cyc = 0;
    while (!BUSY && cyc < 5) begin
      tick(1);
      cyc++;
    end
    check("rst_mid_busy", BUSY, 1'b1);
    RST = 1'b1;
    #1;
    check("rst_mid_ack", ACK, 4'b0000);
    check("rst_mid_winc", WINC, 1'b0);
    tick(1);
    check("rst_mid_gnt", GNT, 2'd0);
    check("rst_mid_busy0", BUSY, 1'b0);
    check("rst_mid_stat", STAT_CNT, 16'd0);
    RST = 1'b0; REQ = 4'b0000;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 16'd0;
    check_stat(2'd3, "rst_cnt3");

    // Pointer restarts at 0 after reset: requester 1 beats requester 3.
    base = nwr;
    push(2'd1, 8'hD1);
    REQ = 4'b1010;
    wait_writes(base + 1, "post_rst_write", cyc);
    REQ = 4'b0000;
    tick(2);
    check_stat(2'd1, "post_rst_stat");
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter DSIZE, default 8: data width of each requester word and of WDATA.
REQ-002 SHALL have parameter BURST, default 4: maximum words accepted per grant when burst mode is compiled in.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port REQ  input  4  per-requester "word valid"; REQ[i] held with DIN slice i stable until ACK[i].
REQ-006 SHALL have port DIN  input  4*DSIZE  requester data; slice i is bits [i*DSIZE +: DSIZE].
REQ-007 SHALL have port ACK  output  4  one-hot, combinational; ACK[i]=1 means the slice-i word is written on this edge.
REQ-008 SHALL have port WDATA  output  DSIZE  FIFO write data, combinational mux of the granted slice.
REQ-009 SHALL have port WINC  output  1  FIFO write strobe, combinational, equal to OR of ACK.
REQ-010 SHALL have port WFULL  input  1  FIFO full flag; no write while high.
REQ-011 SHALL have port GNT  output  2  registered index of current grantee.
REQ-012 SHALL have port BUSY  output  1  registered, 1 while in state XFER.
REQ-013 SHALL have port STAT_SEL  input  2  selects requester for statistics readout/clear.
REQ-014 SHALL have port STAT_CLR  input  1  clears the selected word counter on the next edge.
REQ-015 SHALL have port STAT_CNT  output  16  registered accepted-word count of requester STAT_SEL.

Function
REQ-016 SHALL implement two states: IDLE, XFER.
REQ-017 In IDLE, with any REQ high, SHALL select the first requester at or after pointer PTR (circular 0..3), load GNT, clear burst count, enter XFER next cycle; no ACK in IDLE (1-cycle arbitration latency).
REQ-018 In IDLE with REQ==0 SHALL remain in IDLE, GNT unchanged.
REQ-019 In XFER, ACK[GNT] SHALL equal REQ[GNT] & ~WFULL & ~RST; all other ACK bits 0.
REQ-020 WDATA SHALL always present DIN slice GNT; WINC SHALL equal |ACK.
REQ-021 While WFULL=1 in XFER: no ACK, burst count held, state held (no timeout).
REQ-022 XFER SHALL return to IDLE on the edge where REQ[GNT]=0, or where an accepted word brings burst count to the limit (REQ-031/032).
REQ-023 On leaving XFER, PTR SHALL become (GNT+1) mod 4.
REQ-024 Burst count SHALL increment by 1 per accepted word, width ceil(log2(BURST+1)).
REQ-025 Word counter i SHALL increment by 1 on each ACK[i], wrapping 0xFFFF->0x0000.
REQ-026 STAT_CLR with simultaneous ACK on the selected requester SHALL yield 0 (clear wins).
REQ-027 STAT_CNT SHALL update one cycle after counter or STAT_SEL change.
REQ-028 REQ[GNT] dropping while WFULL=1 SHALL return to IDLE with no write.

Reset
REQ-029 On RST=1 at an edge: state IDLE, PTR=0, GNT=0, BUSY=0, burst count 0, all word counters 0, STAT_CNT=0.
REQ-030 While RST=1, ACK and WINC SHALL be 0, including mid-burst; no word is lost-counted.

Configuration
REQ-031 With macro FIFO_WR_ARB_BURST_EN defined, grant SHALL be held for up to BURST accepted words.
REQ-032 Without FIFO_WR_ARB_BURST_EN, limit SHALL be 1 word per grant; BURST parameter ignored.

Verification
REQ-033 REQ=4'b1111 held, WFULL=0, burst on, BURST=4 -> 4 ACKs to 0, 1 idle cycle, 4 to 1, then 2, 3; GNT 0,1,2,3.
REQ-034 Same stimulus, burst off -> ACK order 0,1,2,3,0 with one idle cycle between words.
REQ-035 REQ[2] only, WFULL high 3 cycles mid-burst -> no WINC those cycles, words resume, burst count 4 total, WDATA matches DIN slice 2 in order.
REQ-036 RST asserted during XFER after 2 words -> ACK=0 that cycle, next cycle GNT=0, BUSY=0, STAT_CNT=0.
REQ-037 Counter 1 preloaded by 65535 accepted words, one more ACK[1] -> STAT_CNT (STAT_SEL=1)=0; STAT_CLR with ACK[1] same cycle -> 0.
